dnu_lut_update_ctrl: RTL and testbench
======================================

DNU_LUT_UPDATE_CTRL -- requirements
Module: dnu_lut_update_ctrl

Interface
REQ-001 Parameters SHALL be: ENTRY_ADDR, default 7, LUT page address width including frame bit; BANK_NUM, default 2, LUT banks per write word; LUT_PORT_SIZE, default 1, bits per bank; PAGE_NUM, default 2**(ENTRY_ADDR-1), pages per frame.
REQ-002 write_clk  input  1  sole clock, rising edge.
REQ-003 rstn  input  1  asynchronous active-low reset.
REQ-004 update_req  input  1  one-cycle request to load a new LUT set (iteration update).
REQ-005 src_valid  input  1  source word valid.
REQ-006 src_data  input  LUT_PORT_SIZE*BANK_NUM  source LUT word, MSB part = bank0, LSB part = bank1.
REQ-007 src_ready  output  1  controller accepts src_data.
REQ-008 swap_en  input  1  decoder permits read-frame swap (no DNU read in flight).
REQ-009 page_addr_ram  output  ENTRY_ADDR  write address: MSB = write frame offset, LSBs = page index.
REQ-010 ram_write_data_1  output  LUT_PORT_SIZE*BANK_NUM  registered write word.
REQ-011 ib_ram_we  output  1  LUT write enable.
REQ-012 read_addr_offset  output  1  active read frame for the DNU LUT.
REQ-013 update_busy  output  1  high in any state other than IDLE.
REQ-014 update_done  output  1  one-cycle pulse on frame swap.
REQ-015 req_drop  output  1  one-cycle pulse when update_req is ignored.

Function
REQ-016 FSM states SHALL be IDLE, LOAD, WAIT_SWAP; encoding free.
REQ-017 IDLE: update_req=1 -> LOAD next cycle; page counter cleared to 0; write frame latched as ~read_addr_offset.
REQ-018 LOAD: src_ready SHALL be 1; a beat is accepted when src_valid & src_ready.
REQ-019 Beat accepted in cycle n -> cycle n+1: ib_ram_we=1, ram_write_data_1=src_data, page_addr_ram={write frame, page counter value at n}.
REQ-020 ib_ram_we SHALL be 0 in every cycle not following an accepted beat; page_addr_ram and ram_write_data_1 hold their last values when ib_ram_we=0.
REQ-021 Page counter increments by 1 per accepted beat; beat with counter=PAGE_NUM-1 is the last: counter wraps to 0 and FSM enters WAIT_SWAP next cycle.
REQ-022 src_valid gaps in LOAD SHALL stall without timeout; no write issued.
REQ-023 WAIT_SWAP and IDLE: src_ready=0.
REQ-024 WAIT_SWAP: swap_en=1 in cycle m -> cycle m+1: read_addr_offset toggles, update_done=1 for one cycle, FSM in IDLE.
REQ-025 Writes SHALL never target the frame equal to current read_addr_offset.
REQ-026 update_req while update_busy=1, or in the same cycle as the WAIT_SWAP->IDLE transition, SHALL be ignored and req_drop pulses in the next cycle; state unaffected.
REQ-027 swap_en outside WAIT_SWAP SHALL have no effect.
REQ-028 Final write (from last beat) SHALL complete before read_addr_offset can toggle (toggle earliest 2 cycles after last-beat acceptance).

Reset
REQ-029 rstn=0 SHALL immediately force: FSM=IDLE, page counter=0, read_addr_offset=0, src_ready=0, ib_ram_we=0, page_addr_ram=0, ram_write_data_1=0, update_busy=0, update_done=0, req_drop=0.
REQ-030 Reset mid-LOAD SHALL abandon the partial load; read_addr_offset returns to 0; no write occurs after rstn assertion.
REQ-031 All state SHALL leave reset on the first write_clk edge after rstn deasserts; no request is remembered across reset.

Verification
REQ-032 Full load: reset, update_req, 64 back-to-back beats data=2'b10 -> 64 writes, addresses 7'h40..7'h7F, data 2'b10, busy high; swap_en=1 -> read_addr_offset=1, update_done one pulse.
REQ-033 Second load after REQ-032: addresses 7'h00..7'h3F; after swap read_addr_offset=0.
REQ-034 Throttled source: src_valid every third cycle -> ib_ram_we exactly one cycle after each acceptance, 64 writes total, page order monotonic.
REQ-035 Overlap: update_req during LOAD at beat 10 -> req_drop pulse next cycle, page count continues 11.., no restart.
REQ-036 swap_en held 0 in WAIT_SWAP for 20 cycles -> no toggle, busy=1, src_ready=0; swap_en pulse -> toggle next cycle; swap_en in IDLE -> no toggle.
REQ-037 rstn low after beat 30 -> ib_ram_we=0 immediately, read_addr_offset=0; new update_req after release writes from page 0 at addr 7'h40.

Source files
------------

// File: rtl/dnu_lut_update_ctrl.sv
// dnu_lut_update_ctrl: loads a new DNU LUT set into the inactive frame, then swaps the read frame
// Ports:
//   write_clk, rstn      sole clock (rising edge), asynchronous active-low reset
//   update_req           one-cycle request to start loading a new LUT set
//   src_valid/src_data   source LUT word (MSB part = bank0), accepted while src_ready is high
//   src_ready            high only while loading
//   swap_en              decoder permits swapping the read frame
//   page_addr_ram        registered write address {write frame, page index}
//   ram_write_data_1     registered write word
//   ib_ram_we            write enable, one cycle after each accepted beat
//   read_addr_offset     active read frame
//   update_busy          high whenever a load or swap is pending
//   update_done          one-cycle pulse when the read frame swaps
//   req_drop             one-cycle pulse when an update_req is ignored
module dnu_lut_update_ctrl #(
   parameter int ENTRY_ADDR    = 7,
   parameter int BANK_NUM      = 2,
   parameter int LUT_PORT_SIZE = 1,
   parameter int PAGE_NUM      = 2**(ENTRY_ADDR-1)
) (
   input  logic                              write_clk,
   input  logic                              rstn,
   input  logic                              update_req,
   input  logic                              src_valid,
   input  logic [LUT_PORT_SIZE*BANK_NUM-1:0] src_data,
   output logic                              src_ready,
   input  logic                              swap_en,
   output logic [ENTRY_ADDR-1:0]             page_addr_ram,
   output logic [LUT_PORT_SIZE*BANK_NUM-1:0] ram_write_data_1,
   output logic                              ib_ram_we,
   output logic                              read_addr_offset,
   output logic                              update_busy,
   output logic                              update_done,
   output logic                              req_drop
);
   localparam int PW = ENTRY_ADDR-1;
   localparam int DW = LUT_PORT_SIZE*BANK_NUM;
   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] LOAD      = 2'd1;
   localparam logic [1:0] WAIT_SWAP = 2'd2;
   logic [1:0]    state_q, state_d;
   logic [PW-1:0] page_q, page_d;
   logic [ENTRY_ADDR-1:0] addr_q, addr_d;
   logic [DW-1:0] data_q, data_d;
   logic          wframe_q, wframe_d, rd_off_q, rd_off_d;
   logic          we_q, we_d, done_q, done_d, drop_q, drop_d;
   logic          accept, last;
   assign src_ready        = state_q == LOAD;
   assign update_busy      = state_q != IDLE;
   assign accept           = src_valid & src_ready;
   assign last             = page_q == PW'(PAGE_NUM-1);
   assign page_addr_ram    = addr_q;
   assign ram_write_data_1 = data_q;
   assign ib_ram_we        = we_q;
   assign read_addr_offset = rd_off_q;
   assign update_done      = done_q;
   assign req_drop         = drop_q;
   always_comb begin
      state_d  = state_q;
      page_d   = page_q;
      wframe_d = wframe_q;
      rd_off_d = rd_off_q;
      addr_d   = addr_q;
      data_d   = data_q;
      we_d     = 1'b0;
      done_d   = 1'b0;
      // any request while busy (including the swap cycle itself) is dropped
      drop_d   = update_req & (state_q != IDLE);
      case (state_q)
         IDLE: if (update_req) begin
            state_d  = LOAD;
            page_d   = '0;
            // always write the frame the decoder is not reading
            wframe_d = ~rd_off_q;
         end
         LOAD: if (accept) begin
            we_d    = 1'b1;
            addr_d  = {wframe_q, page_q};
            data_d  = src_data;
            page_d  = last ? '0 : page_q + PW'(1);
            state_d = last ? WAIT_SWAP : LOAD;
         end
         WAIT_SWAP: if (swap_en) begin
            state_d  = IDLE;
            rd_off_d = ~rd_off_q;
            done_d   = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge write_clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= IDLE;
         page_q   <= '0;
         wframe_q <= 1'b0;
         rd_off_q <= 1'b0;
         addr_q   <= '0;
         data_q   <= '0;
         we_q     <= 1'b0;
         done_q   <= 1'b0;
         drop_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         page_q   <= page_d;
         wframe_q <= wframe_d;
         rd_off_q <= rd_off_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         we_q     <= we_d;
         done_q   <= done_d;
         drop_q   <= drop_d;
      end
   end
endmodule

// File: tb/tb_dnu_lut_update_ctrl.sv
// tb_dnu_lut_update_ctrl: random and directed stimulus against a queue-based reference model
module tb_dnu_lut_update_ctrl;
   localparam int EA = 7;
   localparam int PN = 64;
   logic write_clk = 0, rstn = 1, update_req = 0, src_valid = 0, swap_en = 0;
   logic [1:0] src_data = 0;
   logic src_ready, ib_ram_we, read_addr_offset, update_busy, update_done, req_drop;
   logic [EA-1:0] page_addr_ram;
   logic [1:0] ram_write_data_1;
   always #5 write_clk = ~write_clk;
   dnu_lut_update_ctrl #(.ENTRY_ADDR(EA), .BANK_NUM(2), .LUT_PORT_SIZE(1), .PAGE_NUM(PN)) dut (
      .write_clk(write_clk), .rstn(rstn), .update_req(update_req), .src_valid(src_valid),
      .src_data(src_data), .src_ready(src_ready), .swap_en(swap_en), .page_addr_ram(page_addr_ram),
      .ram_write_data_1(ram_write_data_1), .ib_ram_we(ib_ram_we), .read_addr_offset(read_addr_offset),
      .update_busy(update_busy), .update_done(update_done), .req_drop(req_drop));
   typedef struct {int due; int addr; int data;} wr_t;
   wr_t wq[$];
   int cyc = 0, phase = 0, beats = 0, frame = 0, m_rd = 0;
   bit exp_done = 0, exp_drop = 0, to_flag = 0;
   int n_chk = 0, n_fail = 0, wcnt = 0, last_addr = 0, last_data = 0;
   // reference model: phase 0 idle, 1 collecting PN beats, 2 awaiting swap permission
   always @(posedge write_clk or negedge rstn) begin
      if (!rstn) begin
         phase = 0; beats = 0; m_rd = 0; exp_done = 0; exp_drop = 0;
         wq.delete();
      end else begin
         cyc++;
         exp_done = 0;
         exp_drop = update_req && phase != 0;
         if (phase == 0) begin
            if (update_req) begin phase = 1; beats = 0; frame = 1 - m_rd; end
         end else if (phase == 1) begin
            if (src_valid) begin
               wq.push_back('{cyc, frame*PN + beats, int'(src_data)});
               beats++;
               if (beats == PN) phase = 2;
            end
         end else if (swap_en) begin
            m_rd = 1 - m_rd; exp_done = 1; phase = 0;
         end
      end
   end
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask
   always @(negedge write_clk) begin
      wr_t e;
      chk("stim_timeout", to_flag, 0);
      if (!rstn) begin
         chk("rst_we", ib_ram_we, 0);
         chk("rst_addr", page_addr_ram, 0);
         chk("rst_data", ram_write_data_1, 0);
         chk("rst_rd", read_addr_offset, 0);
         chk("rst_busy", update_busy, 0);
         chk("rst_ready", src_ready, 0);
         chk("rst_done", update_done, 0);
         chk("rst_drop", req_drop, 0);
         wcnt = 0; last_addr = 0; last_data = 0;
      end else begin
         chk("src_ready", src_ready, phase == 1);
         chk("busy", update_busy, phase != 0);
         chk("read_off", read_addr_offset, m_rd);
         chk("done", update_done, exp_done);
         chk("drop", req_drop, exp_drop);
         if (ib_ram_we) begin
            if (wq.size() == 0) chk("spurious_we", 1, 0);
            else begin
               e = wq.pop_front();
               chk("we_cycle", cyc, e.due);
               chk("addr", page_addr_ram, e.addr);
               chk("data", ram_write_data_1, e.data);
               chk("write_hits_read_frame", page_addr_ram[EA-1] == read_addr_offset, 0);
               last_addr = e.addr; last_data = e.data; wcnt++;
            end
         end else begin
            if (wq.size() != 0 && wq[0].due <= cyc) begin
               chk("missing_we", 0, 1);
               void'(wq.pop_front());
            end
            chk("addr_hold", page_addr_ram, last_addr);
            chk("data_hold", ram_write_data_1, last_data);
         end
         if (exp_done) begin
            chk("writes_per_load", wcnt, PN);
            wcnt = 0;
         end
      end
   end
   task automatic tick; @(posedge write_clk); #1; endtask
   task automatic req; update_req = 1; tick(); update_req = 0; endtask
   task automatic load(input int gap, input bit rnd, input bit ovl);
      int g = 0;
      while (phase == 1 && g < 1000) begin
         src_valid  = (g % gap) == 0;
         src_data   = rnd ? 2'($urandom) : 2'b10;
         update_req = ovl && beats == 10;
         tick(); g++;
      end
      if (g >= 1000) to_flag = 1;
      src_valid = 0; update_req = 0;
   endtask
   task automatic swap_wait(input int n, input bit req_too);
      swap_en = 0;
      repeat (n) tick();
      swap_en = 1; update_req = req_too;
      tick();
      swap_en = 0; update_req = 0;
   endtask
   initial begin
      #2 rstn = 0;
      repeat (3) tick();
      rstn = 1;
      tick();
      req(); load(1, 0, 0); swap_wait(3, 0); repeat (3) tick();
      req(); load(1, 1, 0); swap_wait(2, 0); repeat (2) tick();
      req(); load(3, 1, 0); swap_wait(1, 0); tick();
      req(); load(1, 1, 1); swap_wait(20, 1);
      swap_en = 1; repeat (5) tick(); swap_en = 0;
      req();
      for (int g = 0; g < 200 && beats < 31; g++) begin
         src_valid = 1; src_data = 2'($urandom); tick();
      end
      src_valid = 0; rstn = 0;
      repeat (2) tick();
      rstn = 1;
      tick();
      req(); load(1, 1, 0); swap_wait(0, 0); repeat (2) tick();
      repeat (600) begin
         update_req = $urandom_range(19) == 0;
         src_valid  = $urandom_range(1) == 1;
         swap_en    = $urandom_range(3) == 0;
         src_data   = 2'($urandom);
         tick();
      end
      update_req = 0; src_valid = 0; swap_en = 0;
      if (phase == 1) load(1, 1, 0);
      if (phase == 2) swap_wait(1, 0);
      repeat (5) tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
